// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator: immsel encodings
// and the datapath widths the generator supports.
package imm_pkg;

    // Immediate format selector, driven by the decoder alongside the instruction word.
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_NONE  = 3'b111;

    // Supported datapath widths.
    localparam int unsigned XLEN_RV32 = 32;
    localparam int unsigned XLEN_RV64 = 64;

    // True for a datapath width the generator supports.
    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension for the base RISC-V formats.
// Every form is first assembled as a 32-bit value and then widened to XLEN, so
// sign extension above bit 31 (XLEN=64) falls out of a single signed cast.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          HALFWORD_BJ = 1'b0
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      immsel,
    output logic [XLEN-1:0] imm
);

    logic [31:0]            raw;
    logic                   is_bj;
    logic signed [XLEN-1:0] ext;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Assemble the selected form as a 32-bit value with its upper bits already extended.
    always_comb begin
        raw   = '0;
        is_bj = 1'b0;
        case (immsel)
            IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: begin
                raw   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                is_bj = 1'b1;
            end
            IMM_J: begin
                raw   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                is_bj = 1'b1;
            end
            IMM_U:     raw = {instr[31:12], 12'b0};
            // RV64 shifts use a 6-bit amount; RV32 only 5 bits.
            IMM_SHAMT: raw = (XLEN == XLEN_RV64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            IMM_ZIMM:  raw = {27'b0, instr[19:15]};
            default:   raw = '0;
        endcase
    end

    // Zero-extended forms have bit 31 clear, so a signed widening is correct for all forms.
    assign ext = XLEN'($signed(raw));

    // Legacy branch adders take a halfword offset: arithmetic shift keeps the sign.
    always_comb begin
        if (HALFWORD_BJ && is_bj) begin
            imm = ext >>> 1;
        end else begin
            imm = ext;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage. One output register plus a
// one-entry skid register make a 2-entry elastic stage; in_ready comes straight from
// a flop (skid empty), so after out_ready drops at most one further entry is taken.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TAG_W       = 8,
    parameter bit          HALFWORD_BJ = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  in_imm;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic             in_fire;
    logic             out_free;

    imm_extract #(
        .XLEN        (XLEN),
        .HALFWORD_BJ (HALFWORD_BJ)
    ) u_extract (
        .instr  (in_instr),
        .immsel (in_immsel),
        .imm    (in_imm)
    );

    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    // Output register can take a new entry this cycle: empty, or draining now.
    assign out_free = ~out_valid_q | out_ready;

    // Next-state for output and skid registers; flush overrides every transfer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry goes first; a same-cycle input backfills the skid.
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_imm_d = in_imm;
                    skid_tag_d = in_tag;
                end
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_imm_d = in_imm;
                    out_tag_d = in_tag;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the accepted entry in the skid register.
            skid_valid_d = 1'b1;
            skid_imm_d   = in_imm;
            skid_tag_d   = in_tag;
        end
    end

    // State registers with asynchronous reset to an empty, ready stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Three instances share one input bus:
// XLEN=32, XLEN=64, and XLEN=32 with halfword B/J offsets.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immsel;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_imm_a;
    logic [7:0]  out_tag_a;
    logic        in_ready_w, out_valid_w;
    logic [63:0] out_imm_w;
    logic [7:0]  out_tag_w;
    logic        in_ready_h, out_valid_h;
    logic [31:0] out_imm_h;
    logic [7:0]  out_tag_h;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .HALFWORD_BJ(1'b0)) dut_a (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready_a), .in_instr (in_instr),
        .in_immsel (in_immsel), .in_tag (in_tag),
        .out_valid (out_valid_a), .out_ready (out_ready), .out_imm (out_imm_a),
        .out_tag (out_tag_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .HALFWORD_BJ(1'b0)) dut_w (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready_w), .in_instr (in_instr),
        .in_immsel (in_immsel), .in_tag (in_tag),
        .out_valid (out_valid_w), .out_ready (out_ready), .out_imm (out_imm_w),
        .out_tag (out_tag_w)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .HALFWORD_BJ(1'b1)) dut_h (
        .clk (clk), .rst_n (rst_n), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready_h), .in_instr (in_instr),
        .in_immsel (in_immsel), .in_tag (in_tag),
        .out_valid (out_valid_h), .out_ready (out_ready), .out_imm (out_imm_h),
        .out_tag (out_tag_h)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [2:0] sel, input logic [7:0] tag);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_immsel = sel;
        in_tag    = tag;
    endtask

    // Vector table: instruction, format, expected for XLEN32 / XLEN64 / halfword B/J.
    localparam int NV = 9;
    logic [31:0] v_instr [NV];
    logic [2:0]  v_sel   [NV];
    logic [31:0] v_exp32 [NV];
    logic [63:0] v_exp64 [NV];
    logic [31:0] v_exphw [NV];

    initial begin
        v_instr[0] = 32'hFFC12083; v_sel[0] = 3'd0; v_exp32[0] = 32'hFFFFFFFC;
        v_exp64[0] = 64'hFFFFFFFFFFFFFFFC; v_exphw[0] = 32'hFFFFFFFC;
        v_instr[1] = 32'h00512423; v_sel[1] = 3'd1; v_exp32[1] = 32'h00000008;
        v_exp64[1] = 64'h0000000000000008; v_exphw[1] = 32'h00000008;
        v_instr[2] = 32'hFE000CE3; v_sel[2] = 3'd2; v_exp32[2] = 32'hFFFFFFF8;
        v_exp64[2] = 64'hFFFFFFFFFFFFFFF8; v_exphw[2] = 32'hFFFFFFFC;
        v_instr[3] = 32'h0010006F; v_sel[3] = 3'd3; v_exp32[3] = 32'h00000800;
        v_exp64[3] = 64'h0000000000000800; v_exphw[3] = 32'h00000400;
        v_instr[4] = 32'h123450B7; v_sel[4] = 3'd4; v_exp32[4] = 32'h12345000;
        v_exp64[4] = 64'h0000000012345000; v_exphw[4] = 32'h12345000;
        v_instr[5] = 32'h800000B7; v_sel[5] = 3'd4; v_exp32[5] = 32'h80000000;
        v_exp64[5] = 64'hFFFFFFFF80000000; v_exphw[5] = 32'h80000000;
        v_instr[6] = 32'h03F00013; v_sel[6] = 3'd5; v_exp32[6] = 32'h0000001F;
        v_exp64[6] = 64'h000000000000003F; v_exphw[6] = 32'h0000001F;
        v_instr[7] = 32'h800F8073; v_sel[7] = 3'd6; v_exp32[7] = 32'h0000001F;
        v_exp64[7] = 64'h000000000000001F; v_exphw[7] = 32'h0000001F;
        v_instr[8] = 32'hFFFFFFFF; v_sel[8] = 3'd7; v_exp32[8] = 32'h00000000;
        v_exp64[8] = 64'h0000000000000000; v_exphw[8] = 32'h00000000;
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_immsel = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        check("rst_out_imm", 64'(out_imm_a), 64'd0);
        check("rst_out_tag", 64'(out_tag_a), 64'd0);
        check("rst_out_imm64", out_imm_w, 64'd0);
        #9 rst_n = 1'b1;

        // All formats, one per cycle, full throughput
        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            present(v_instr[i], v_sel[i], 8'(20 + i));
            tick();
            check($sformatf("vec%0d_valid", i), 64'(out_valid_a), 64'd1);
            check($sformatf("vec%0d_tag", i), 64'(out_tag_a), 64'(20 + i));
            check($sformatf("vec%0d_imm32", i), 64'(out_imm_a), 64'(v_exp32[i]));
            check($sformatf("vec%0d_imm64", i), out_imm_w, v_exp64[i]);
            check($sformatf("vec%0d_immhw", i), 64'(out_imm_h), 64'(v_exphw[i]));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid_a), 64'd0);

        // Backpressure: 4 stalled cycles with tags 1,2,3 offered
        out_ready = 1'b0;
        present(32'hFFC12083, 3'd0, 8'd1);
        tick();
        check("bp1_tag", 64'(out_tag_a), 64'd1);
        check("bp1_in_ready", 64'(in_ready_a), 64'd1);
        present(32'h00512423, 3'd1, 8'd2);
        tick();
        check("bp2_in_ready", 64'(in_ready_a), 64'd0);
        check("bp2_tag", 64'(out_tag_a), 64'd1);
        present(32'h0010006F, 3'd3, 8'd3);
        tick();
        check("bp3_in_ready", 64'(in_ready_a), 64'd0);
        tick();
        check("bp4_tag_hold", 64'(out_tag_a), 64'd1);
        check("bp4_imm_hold", 64'(out_imm_a), 64'hFFFFFFFC);
        check("bp4_valid", 64'(out_valid_a), 64'd1);
        out_ready = 1'b1;
        tick();
        check("rel1_tag", 64'(out_tag_a), 64'd2);
        check("rel1_imm", 64'(out_imm_a), 64'h8);
        check("rel1_in_ready", 64'(in_ready_a), 64'd1);
        tick();
        in_valid = 1'b0;
        check("rel2_tag", 64'(out_tag_a), 64'd3);
        check("rel2_imm", 64'(out_imm_a), 64'h800);
        check("rel2_valid", 64'(out_valid_a), 64'd1);
        tick();
        check("rel3_valid", 64'(out_valid_a), 64'd0);

        // Flush with output and skid full (tags 5,6) and tag 7 offered
        out_ready = 1'b0;
        present(32'hFFC12083, 3'd0, 8'd5);
        tick();
        present(32'h00512423, 3'd1, 8'd6);
        tick();
        check("fl_full_in_ready", 64'(in_ready_a), 64'd0);
        present(32'h0010006F, 3'd3, 8'd7);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid_a), 64'd0);
        check("fl_in_ready", 64'(in_ready_a), 64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_no_tag7_a", 64'(out_valid_a), 64'd0);
        tick();
        check("fl_no_tag7_b", 64'(out_valid_a), 64'd0);

        // Flush discards an input that would otherwise be accepted
        out_ready = 1'b0;
        present(32'hFFC12083, 3'd0, 8'd5);
        tick();
        present(32'h0010006F, 3'd3, 8'd8);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_out_valid", 64'(out_valid_a), 64'd0);
        check("fl2_in_ready", 64'(in_ready_a), 64'd1);

        // Asynchronous reset mid-stall, between clock edges
        present(32'hFFC12083, 3'd0, 8'd9);
        tick();
        present(32'h00512423, 3'd1, 8'd10);
        tick();
        in_valid = 1'b0;
        check("ar_pre_in_ready", 64'(in_ready_a), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid_a), 64'd0);
        check("ar_in_ready", 64'(in_ready_a), 64'd1);
        check("ar_out_tag", 64'(out_tag_a), 64'd0);
        check("ar_out_imm", 64'(out_imm_a), 64'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        present(32'h123450B7, 3'd4, 8'd11);
        tick();
        in_valid = 1'b0;
        check("ar_post_valid", 64'(out_valid_a), 64'd1);
        check("ar_post_tag", 64'(out_tag_a), 64'd11);
        check("ar_post_imm64", out_imm_w, 64'h0000000012345000);
        tick();
        check("ar_post_drain", 64'(out_valid_a), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
